// File: rtl/ifm_fifo_ctrl_if.sv
// Handshake/bus bundle between the IFM ping-pong FIFO controller and its
// upstream source and FIFO banks.
interface ifm_fifo_ctrl_if #(
    parameter int NUM_FIFO = 16,
    parameter int CW       = 13
);
    logic                start;
    logic [7:0]          num_tiles;
    logic [CW-1:0]       tile_len;
    logic [4:0]          ifm_size;
    logic                in_valid;
    logic                in_ready;
    logic                wr_en_1, wr_en_2;
    logic                wr_clr_1, wr_clr_2;
    logic                rd_clr_1, rd_clr_2;
    logic [NUM_FIFO-1:0] rd_en_1, rd_en_2;
    logic                ifm_demux, ifm_mux;
    logic [4:0]          read_ifm_size;
    logic                busy, done;

    modport master (
        output start, num_tiles, tile_len, ifm_size, in_valid,
        input  in_ready, wr_en_1, wr_en_2, wr_clr_1, wr_clr_2, rd_clr_1, rd_clr_2,
               rd_en_1, rd_en_2, ifm_demux, ifm_mux, read_ifm_size, busy, done
    );

    modport slave (
        input  start, num_tiles, tile_len, ifm_size, in_valid,
        output in_ready, wr_en_1, wr_en_2, wr_clr_1, wr_clr_2, rd_clr_1, rd_clr_2,
               rd_en_1, rd_en_2, ifm_demux, ifm_mux, read_ifm_size, busy, done
    );
endinterface

// File: rtl/ifm_fifo_ctrl.sv
// Ping-pong IFM FIFO sequencer: fills one bank while the other is read out with
// a per-lane one-cycle skew. Define IFM_FIFO_CTRL_PERF_EN to add stall_cycles.
module ifm_fifo_ctrl #(
    parameter int  NUM_FIFO          = 16,
    parameter int  MAX_WGT_FIFO_SIZE = 4608,
    localparam int CW                = $clog2(MAX_WGT_FIFO_SIZE + 1),
    localparam int RW                = $clog2(MAX_WGT_FIFO_SIZE + NUM_FIFO + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
`ifdef IFM_FIFO_CTRL_PERF_EN
    output logic [31:0]  stall_cycles,
`endif
    ifm_fifo_ctrl_if.slave bus
);

    typedef enum logic [2:0] {IDLE, CLR, PRIME, STEADY, SWAP, DONE} state_t;

    state_t              state_q, state_d;
    logic [7:0]          nt_q;
    logic [CW-1:0]       tl_q, tl_sat;
    logic [4:0]          sz_q, eff_sz;
    logic [CW-1:0]       wr_cnt_q, wr_cnt_d;
    logic [7:0]          wr_tiles_q, wr_tiles_d, rd_tiles_q, rd_tiles_d;
    logic                wr_act_q, wr_act_d;
    logic [RW-1:0]       rd_cnt_q, rd_cnt_d, rd_len;
    logic [NUM_FIFO-1:0] sk_q, sk_d, lane_mask;
    logic [NUM_FIFO-1:0] rd1_q, rd2_q, rd1_d, rd2_d;
    logic                in_ready_q, in_ready_d;
    logic                demux_q, demux_d, mux_q, mux_d;
    logic [3:0]          clr_q, clr_d;    // {wr_clr_1, wr_clr_2, rd_clr_1, rd_clr_2}
    logic                busy_q, done_q, base_d;
    logic                accept, acc, wr_last, wr_fin, rd_last, rd_cmp;

    assign tl_sat  = (bus.tile_len > CW'(MAX_WGT_FIFO_SIZE)) ? CW'(MAX_WGT_FIFO_SIZE) : bus.tile_len;
    assign accept  = (state_q == IDLE) && bus.start;
    assign acc     = bus.in_valid && in_ready_q;
    assign wr_last = acc && (wr_cnt_q + CW'(1) == tl_q);
    assign wr_fin  = !wr_act_q || (wr_cnt_q == tl_q) || wr_last;
    // Pass spans the base strobe plus the skew tail of the last lane.
    assign rd_len  = RW'(tl_q) + RW'(NUM_FIFO - 1);
    assign rd_last = rd_cnt_q >= rd_len - RW'(1);
    assign rd_cmp  = rd_cnt_q >= rd_len;

    always_comb begin
        eff_sz = (sz_q == 5'd0 || sz_q > 5'd16) ? 5'd16 : sz_q;
        for (int i = 0; i < NUM_FIFO; i++) lane_mask[i] = (i < int'(eff_sz));
    end

    always_comb begin
        state_d    = state_q;
        wr_cnt_d   = wr_cnt_q + CW'(acc);
        wr_tiles_d = wr_last ? wr_tiles_q + 8'd1 : wr_tiles_q;
        rd_tiles_d = rd_tiles_q;
        wr_act_d   = wr_act_q;
        rd_cnt_d   = (state_q == STEADY && !rd_cmp) ? rd_cnt_q + RW'(1) : rd_cnt_q;
        demux_d    = demux_q;
        mux_d      = mux_q;
        clr_d      = 4'b0000;
        case (state_q)
            IDLE: if (accept) begin
                state_d    = CLR;
                clr_d      = 4'b1111;
                demux_d    = 1'b0;
                mux_d      = 1'b1;
                wr_cnt_d   = '0;
                wr_tiles_d = '0;
                rd_tiles_d = '0;
                rd_cnt_d   = '0;
                wr_act_d   = 1'b0;
            end
            CLR: begin
                state_d  = (nt_q == 8'd0 || tl_q == '0) ? DONE : PRIME;
                wr_cnt_d = '0;
            end
            PRIME: if (wr_last) state_d = SWAP;
            SWAP: begin
                mux_d    = demux_q;
                demux_d  = ~demux_q;
                clr_d    = demux_q ? 4'b1010 : 4'b0101;
                wr_cnt_d = '0;
                rd_cnt_d = '0;
                wr_act_d = wr_tiles_q < nt_q;
                state_d  = (rd_tiles_q < nt_q) ? STEADY : DONE;
            end
            STEADY: if (rd_last && wr_fin) begin
                state_d    = SWAP;
                rd_tiles_d = rd_tiles_q + 8'd1;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from next-state values so they line up with the state.
    always_comb begin
        in_ready_d = (state_d == PRIME) ||
                     (state_d == STEADY && wr_act_d && wr_cnt_d != tl_q);
        base_d     = (state_d == STEADY) && (rd_cnt_d < RW'(tl_q));
        sk_d       = NUM_FIFO'({sk_q, base_d});
        rd1_d      = mux_d ? '0 : (sk_d & lane_mask);
        rd2_d      = mux_d ? (sk_d & lane_mask) : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            nt_q       <= '0;
            tl_q       <= '0;
            sz_q       <= '0;
            wr_cnt_q   <= '0;
            wr_tiles_q <= '0;
            rd_tiles_q <= '0;
            wr_act_q   <= 1'b0;
            rd_cnt_q   <= '0;
            sk_q       <= '0;
            rd1_q      <= '0;
            rd2_q      <= '0;
            in_ready_q <= 1'b0;
            demux_q    <= 1'b0;
            mux_q      <= 1'b0;
            clr_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_cnt_q   <= wr_cnt_d;
            wr_tiles_q <= wr_tiles_d;
            rd_tiles_q <= rd_tiles_d;
            wr_act_q   <= wr_act_d;
            rd_cnt_q   <= rd_cnt_d;
            sk_q       <= sk_d;
            rd1_q      <= rd1_d;
            rd2_q      <= rd2_d;
            in_ready_q <= in_ready_d;
            demux_q    <= demux_d;
            mux_q      <= mux_d;
            clr_q      <= clr_d;
            busy_q     <= state_d != IDLE;
            done_q     <= state_d == DONE;
            if (accept) begin
                nt_q <= bus.num_tiles;
                tl_q <= tl_sat;
                sz_q <= bus.ifm_size;
            end
        end
    end

`ifdef IFM_FIFO_CTRL_PERF_EN
    // Cycles spent waiting on the writer after the read pass has drained.
    always_ff @(posedge clk) begin
        if (!rst_n || accept)
            stall_cycles <= '0;
        else if (state_q == STEADY && rd_cmp && stall_cycles != '1)
            stall_cycles <= stall_cycles + 32'd1;
    end
`endif

    assign bus.in_ready      = in_ready_q;
    assign bus.wr_en_1       = bus.in_valid && in_ready_q && !demux_q;
    assign bus.wr_en_2       = bus.in_valid && in_ready_q && demux_q;
    assign bus.wr_clr_1      = clr_q[3];
    assign bus.wr_clr_2      = clr_q[2];
    assign bus.rd_clr_1      = clr_q[1];
    assign bus.rd_clr_2      = clr_q[0];
    assign bus.rd_en_1       = rd1_q;
    assign bus.rd_en_2       = rd2_q;
    assign bus.ifm_demux     = demux_q;
    assign bus.ifm_mux       = mux_q;
    assign bus.read_ifm_size = sz_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;

endmodule

// File: tb/tb_ifm_fifo_ctrl.sv
// Scoreboard bench for ifm_fifo_ctrl: expected bank order per tile is queued at
// job launch and popped as writes/read passes are observed.
module tb_ifm_fifo_ctrl;
    localparam int NF  = 16;
    localparam int MAX = 20;
    localparam int CW  = $clog2(MAX + 1);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ifm_fifo_ctrl_if #(.NUM_FIFO(NF), .CW(CW)) b ();
`ifdef IFM_FIFO_CTRL_PERF_EN
    logic [31:0] stall_cycles;
`endif

    ifm_fifo_ctrl #(.NUM_FIFO(NF), .MAX_WGT_FIFO_SIZE(MAX)) dut (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef IFM_FIFO_CTRL_PERF_EN
        .stall_cycles (stall_cycles),
`endif
        .bus   (b)
    );

    int total = 0, bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // scoreboard / monitor state
    int q_wr[$], q_rd[$];
    bit mon_en = 0;
    int cur_tl, lane_l, wcnt, wtile, rtile, rlen, sk_idx, viol, ndone, done_cyc;
    int wc1, wc2, cur_wb, cur_rb, exp_stall;
    int last_wr [0:63];
    int rstart  [0:63];
    bit prev_rd0, prev_rdl;
    logic [NF-1:0] cur_mask;

    always @(negedge clk) begin
        logic [NF-1:0] rdv;
        int wb, e, pe;
        if (rst_n && mon_en) begin
            if (b.wr_en_1 || b.wr_en_2) begin
                wb = b.wr_en_2 ? 2 : 1;
                if (b.wr_en_1 && b.wr_en_2) viol++;
                if (wcnt == 0) begin
                    if (q_wr.size() == 0) begin chk("wr_extra", 1, 0); cur_wb = 0; end
                    else begin cur_wb = q_wr.pop_front(); chk("wr_bank", wb, cur_wb); end
                end else if (wb != cur_wb) viol++;
                wcnt++;
                if (wcnt == cur_tl) begin last_wr[wtile] = cyc; wtile++; wcnt = 0; end
            end
            rdv = b.rd_en_1 | b.rd_en_2;
            if (|b.rd_en_1 && |b.rd_en_2) viol++;
            if (|(rdv & ~cur_mask)) viol++;
            if ((b.wr_en_1 && |b.rd_en_1) || (b.wr_en_2 && |b.rd_en_2)) viol++;
            if (rdv[0] && !prev_rd0) begin
                if (q_rd.size() == 0) begin chk("rd_extra", 1, 0); cur_rb = 0; end
                else begin cur_rb = q_rd.pop_front(); chk("rd_bank", b.rd_en_2[0] ? 2 : 1, cur_rb); end
                if (rtile == 0) e = last_wr[0] + 2;
                else begin
                    pe = rstart[rtile-1] + cur_tl + NF - 2;
                    e  = (last_wr[rtile] > pe ? last_wr[rtile] : pe) + 2;
                    if (last_wr[rtile] > pe) exp_stall += last_wr[rtile] - pe;
                end
                chk("rd_start", cyc, e);
                rstart[rtile] = cyc;
                rlen = 0;
            end
            if (rdv[0]) begin
                rlen++;
                if ((b.rd_en_2[0] ? 2 : 1) != cur_rb) viol++;
            end
            if (!rdv[0] && prev_rd0) begin chk("rd_len", rlen, cur_tl); rtile++; end
            if (rdv[lane_l] && !prev_rdl) begin
                chk("skew", cyc - rstart[sk_idx], lane_l);
                sk_idx++;
            end
            prev_rd0 = rdv[0];
            prev_rdl = rdv[lane_l];
            wc1 += int'(b.wr_clr_1);
            wc2 += int'(b.wr_clr_2);
            if (b.wr_clr_1 != b.rd_clr_1 || b.wr_clr_2 != b.rd_clr_2) viol++;
            if (b.done) begin ndone++; done_cyc = cyc; end
        end
    end

    function automatic logic [63:0] outs();
        return {b.in_ready, b.wr_en_1, b.wr_en_2, b.wr_clr_1, b.wr_clr_2, b.rd_clr_1,
                b.rd_clr_2, |b.rd_en_1, |b.rd_en_2, b.ifm_demux, b.ifm_mux,
                b.read_ifm_size, b.busy, b.done};
    endfunction

    task automatic run_job(input int nt, input int tl, input int sz, input int per);
        int etl, esz, st, k, nw;
        etl = (tl > MAX) ? MAX : tl;
        esz = (sz == 0 || sz > 16) ? 16 : sz;
        nw  = (etl == 0) ? 0 : nt;
        q_wr.delete(); q_rd.delete();
        for (int i = 0; i < nw; i++) begin
            q_wr.push_back((i % 2) ? 2 : 1);
            q_rd.push_back((i % 2) ? 2 : 1);
        end
        cur_tl = etl; lane_l = esz - 1;
        for (int i = 0; i < NF; i++) cur_mask[i] = (i < esz);
        wcnt = 0; wtile = 0; rtile = 0; rlen = 0; sk_idx = 0; viol = 0; ndone = 0;
        done_cyc = 0; wc1 = 0; wc2 = 0; exp_stall = 0; prev_rd0 = 0; prev_rdl = 0;
        for (int i = 0; i < 64; i++) begin last_wr[i] = 0; rstart[i] = 0; end
        mon_en = 1;
        @(posedge clk); #1;
        b.start = 1'b1; b.num_tiles = 8'(nt); b.tile_len = CW'(tl);
        b.ifm_size = 5'(sz); b.in_valid = 1'b1;
        st = cyc;
        @(posedge clk); #1;
        // start held with junk params while busy; must be ignored
        b.num_tiles = 8'd7; b.tile_len = CW'(3); b.ifm_size = 5'd2;
        chk("busy_on", b.busy, 1);
        chk("clr_cycle", {b.wr_clr_1, b.wr_clr_2, b.rd_clr_1, b.rd_clr_2, b.ifm_demux, b.ifm_mux}, 6'b111101);
        chk("rd_size", b.read_ifm_size, sz);
        b.start = 1'b0;
        k = 1;
        while (ndone == 0 && k < 3000) begin
            @(posedge clk); #1;
            k++;
            b.in_valid = ((k % per) == 0);
        end
        if (ndone == 0) chk("timeout", 0, 1);
        b.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        mon_en = 0;
        chk("busy_off", b.busy, 0);
        chk("done_cnt", ndone, 1);
        if (nw == 0) chk("done_at", done_cyc - st, 2);
        else begin
            chk("done_at", done_cyc, rstart[nw-1] + etl + NF);
            if (per == 1) chk("done_abs", done_cyc - st, etl + 3 + nw * (etl + NF));
        end
        chk("wr_tiles", wtile, nw);
        chk("wr_rem", wcnt, 0);
        chk("rd_tiles", rtile, nw);
        chk("q_left", q_wr.size() + q_rd.size(), 0);
        chk("viol", viol, 0);
        chk("clr1", wc1, 1 + ((nw > 0) ? (nw + 1) / 2 : 0));
        chk("clr2", wc2, 1 + ((nw > 0) ? (nw + 2) / 2 : 0));
`ifdef IFM_FIFO_CTRL_PERF_EN
        chk("stall", stall_cycles, exp_stall);
`endif
    endtask

    task automatic reset_mid();
        int k;
        mon_en = 0;
        @(posedge clk); #1;
        b.start = 1'b1; b.num_tiles = 8'd3; b.tile_len = CW'(8); b.ifm_size = 5'd16; b.in_valid = 1'b1;
        @(posedge clk); #1;
        b.start = 1'b0;
        k = 0;
        while (!(|b.rd_en_1 || |b.rd_en_2) && k < 200) begin @(posedge clk); #1; k++; end
        chk("rst_reach", k < 200, 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst_outs", outs(), 0);
        chk("rst_busy", b.busy, 0);
        rst_n = 1'b1;
        b.in_valid = 1'b0;
        @(posedge clk); #1;
        chk("rst_idle", outs(), 0);
    endtask

    initial begin
        b.start = 1'b0; b.num_tiles = '0; b.tile_len = '0; b.ifm_size = '0; b.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", outs(), 0);
        rst_n = 1'b1;
        run_job(1, 4, 16, 1);
        run_job(3, 8, 16, 1);
        run_job(2, 6, 5, 1);
        run_job(2, 16, 16, 2);
        run_job(3, 5, 0, 3);
        run_job(0, 4, 16, 1);
        run_job(2, 0, 16, 1);
        run_job(1, 25, 9, 1);
        reset_mid();
        run_job(1, 4, 16, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
